// File: rtl/issue_scheduler_if.sv
// Handshake and status bundle between decode/datapath and the issue scheduler.
// Latency: none (wires only).
// Backpressure: decReady gates decode; memReq/memAck pace the data cache.
interface issue_scheduler_if;
    // Decode side
    logic        decValid;
    logic        decReady;
    logic [2:0]  opType;
    logic [4:0]  readRegister1;
    logic [4:0]  readRegister2;
    logic [4:0]  writeRegister;
    logic        regWriteFlag;
    // Writeback
    logic        wbValid;
    logic [4:0]  wbRegister;
    // Data cache
    logic        memReq;
    logic        memAck;
    // Branch resolution
    logic        branchResolved;
    logic        branchTaken;
    // Status
    logic        issue;
    logic        flush;
    logic [2:0]  inflightCount;
    logic [15:0] stallCount;

    // Decode/datapath side
    modport master (
        output decValid, opType, readRegister1, readRegister2, writeRegister,
               regWriteFlag, wbValid, wbRegister, memAck, branchResolved, branchTaken,
        input  decReady, memReq, issue, flush, inflightCount, stallCount
    );

    // Scheduler side
    modport slave (
        input  decValid, opType, readRegister1, readRegister2, writeRegister,
               regWriteFlag, wbValid, wbRegister, memAck, branchResolved, branchTaken,
        output decReady, memReq, issue, flush, inflightCount, stallCount
    );
endinterface

// File: rtl/issue_scheduler.sv
// In-order issue scheduler: RAW scoreboard, load/store and branch sequencing, flush.
// Latency: issue is combinational with decValid; memReq/flush appear one edge after issue.
// Backpressure: decReady drops on hazards, full in-flight window, MEM/BRANCH wait, illegal op.
// Ports: clock, resetN (async active-low); bus (slave modport) carries decode,
//        writeback, data-cache, branch and status signals.
module issue_scheduler #(
    parameter int MAX_INFLIGHT = 4
) (
    input  logic              clock,
    input  logic              resetN,
    issue_scheduler_if.slave  bus
);
    localparam logic [2:0] OP_LD = 3'd0;
    localparam logic [2:0] OP_CB = 3'd1;
    localparam logic [2:0] OP_R  = 3'd2;
    localparam logic [2:0] OP_ST = 3'd3;
    localparam logic [2:0] OP_I  = 3'd4;
    localparam logic [2:0] OP_B  = 3'd5;
    localparam logic [2:0] OP_M  = 3'd6;
    localparam logic [2:0] OP_X  = 3'd7;
    localparam logic [4:0] XZR   = 5'd31;
    localparam logic [2:0] MAX_L = 3'(MAX_INFLIGHT);

    typedef enum logic [1:0] {RUN = 2'd0, MEM = 2'd1, BRANCH = 2'd2} state_t;

    state_t      r_state;
    logic [31:0] r_pending;
    logic [2:0]  r_inflight;
    logic [15:0] r_stall;
    logic        r_memReq;
    logic        r_flush;

    logic        w_use1, w_use2, w_busy1, w_busy2, w_hazard, w_room, w_ready, w_issue;
    logic        w_set, w_clr;
    logic [31:0] w_setMask, w_clrMask;

    assign w_use1 = (bus.opType == OP_LD) || (bus.opType == OP_R) || (bus.opType == OP_ST) ||
                    (bus.opType == OP_I)  || (bus.opType == OP_M);
    assign w_use2 = (bus.opType == OP_R) || (bus.opType == OP_CB) || (bus.opType == OP_ST);

    // A register retiring this cycle is already free (writeback bypass).
    // XZR never sets its pending bit, so it can never look busy.
    assign w_busy1 = r_pending[bus.readRegister1] &&
                     !(bus.wbValid && (bus.wbRegister == bus.readRegister1));
    assign w_busy2 = r_pending[bus.readRegister2] &&
                     !(bus.wbValid && (bus.wbRegister == bus.readRegister2));
    assign w_hazard = (w_use1 && w_busy1) || (w_use2 && w_busy2);

    // Non-writing ops and XZR writes do not consume an in-flight slot.
    assign w_room  = (r_inflight < MAX_L) || !bus.regWriteFlag || (bus.writeRegister == XZR);
    assign w_ready = (r_state == RUN) && (bus.opType != OP_X) && !w_hazard && w_room;
    assign w_issue = bus.decValid && w_ready;

    assign w_set     = w_issue && bus.regWriteFlag && (bus.writeRegister != XZR);
    assign w_clr     = bus.wbValid && r_pending[bus.wbRegister];
    assign w_setMask = w_set ? (32'd1 << bus.writeRegister) : 32'd0;
    assign w_clrMask = w_clr ? (32'd1 << bus.wbRegister) : 32'd0;

    // Control FSM with registered memReq/flush.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state  <= RUN;
            r_memReq <= 1'b0;
            r_flush  <= 1'b0;
        end else begin
            r_flush <= 1'b0;
            case (r_state)
                RUN: begin
                    if (w_issue) begin
                        case (bus.opType)
                            OP_LD, OP_ST: begin
                                r_state  <= MEM;
                                r_memReq <= 1'b1;
                            end
                            OP_CB:   r_state <= BRANCH;
                            OP_B:    r_flush <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                MEM: begin
                    if (bus.memAck) begin
                        r_state  <= RUN;
                        r_memReq <= 1'b0;
                    end
                end
                BRANCH: begin
                    if (bus.branchResolved) begin
                        r_state <= RUN;
                        r_flush <= bus.branchTaken;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    // Scoreboard: clear then set, so a same-cycle set of the retiring register wins
    // and the count nets to zero change.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_pending  <= 32'd0;
            r_inflight <= 3'd0;
        end else begin
            r_pending <= (r_pending & ~w_clrMask) | w_setMask;
            case ({w_set, w_clr})
                2'b10:   r_inflight <= r_inflight + 3'd1;
                2'b01:   r_inflight <= r_inflight - 3'd1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Saturating stall counter.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_stall <= 16'd0;
        end else if (bus.decValid && !w_ready && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign bus.decReady      = w_ready;
    assign bus.issue         = w_issue;
    assign bus.memReq        = r_memReq;
    assign bus.flush         = r_flush;
    assign bus.inflightCount = r_inflight;
    assign bus.stallCount    = r_stall;
endmodule

// File: tb/tb_issue_scheduler.sv
module tb_issue_scheduler;
    localparam int MAXI = 4;

    logic clock  = 1'b0;
    logic resetN = 1'b0;
    always #5 clock = ~clock;

    issue_scheduler_if bus ();
    issue_scheduler #(.MAX_INFLIGHT(MAXI)) dut (.clock(clock), .resetN(resetN), .bus(bus));

    int errors = 0;
    int checks = 0;

    // Reference model: pending set, write count, mode (0 run, 1 waiting on cache,
    // 2 waiting on branch), expected registered outputs.
    bit m_pend[32];
    int m_cnt, m_mode, m_stall;
    bit m_memreq, m_flush;

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_cnt = 0; m_mode = 0; m_stall = 0; m_memreq = 1'b0; m_flush = 1'b0;
    endtask

    function automatic bit m_busy(input int r);
        return (r != 31) && m_pend[r] && !(bus.wbValid && (int'(bus.wbRegister) == r));
    endfunction

    function automatic bit m_ready();
        int op;
        op = int'(bus.opType);
        if (m_mode != 0 || op == 7) return 1'b0;
        if ((op == 0 || op == 2 || op == 3 || op == 4 || op == 6) && m_busy(int'(bus.readRegister1))) return 1'b0;
        if ((op == 1 || op == 2 || op == 3) && m_busy(int'(bus.readRegister2))) return 1'b0;
        if (bus.regWriteFlag && bus.writeRegister != 5'd31 && m_cnt >= MAXI) return 1'b0;
        return 1'b1;
    endfunction

    task automatic idle_inputs();
        bus.decValid = 1'b0; bus.opType = 3'd2; bus.readRegister1 = 5'd0; bus.readRegister2 = 5'd0;
        bus.writeRegister = 5'd0; bus.regWriteFlag = 1'b0; bus.wbValid = 1'b0; bus.wbRegister = 5'd0;
        bus.memAck = 1'b0; bus.branchResolved = 1'b0; bus.branchTaken = 1'b0;
    endtask

    task automatic set_op(input int op, input int r1, input int r2, input int wr, input bit rwf);
        bus.decValid = 1'b1; bus.opType = 3'(op); bus.readRegister1 = 5'(r1);
        bus.readRegister2 = 5'(r2); bus.writeRegister = 5'(wr); bus.regWriteFlag = rwf;
    endtask

    // Advance one clock: predict the edge outcome from the current inputs, then step.
    task automatic tick();
        bit rdy, iss;
        int op, wr, wb;
        rdy = m_ready();
        iss = bus.decValid && rdy;
        op = int'(bus.opType); wr = int'(bus.writeRegister); wb = int'(bus.wbRegister);
        @(posedge clock);
        m_flush = iss && (op == 5);
        if (m_mode == 1 && bus.memAck) begin m_mode = 0; m_memreq = 1'b0; end
        else if (m_mode == 2 && bus.branchResolved) begin m_mode = 0; m_flush = bus.branchTaken; end
        if (iss && (op == 0 || op == 3)) begin m_mode = 1; m_memreq = 1'b1; end
        if (iss && op == 1) m_mode = 2;
        if (bus.wbValid && wb != 31 && m_pend[wb]) begin m_pend[wb] = 1'b0; m_cnt--; end
        if (iss && bus.regWriteFlag && wr != 31) begin m_pend[wr] = 1'b1; m_cnt++; end
        if (bus.decValid && !rdy && m_stall < 65535) m_stall++;
        #1;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        #3;
        model_reset();
        idle_inputs();
        @(negedge clock);
        resetN = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        bus.opType = 3'd2; bus.readRegister1 = 5'd1; bus.readRegister2 = 5'd2;
        #1;
        checks++; if (bus.inflightCount !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.inflightCount); end
        checks++; if (bus.stallCount !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", bus.stallCount); end
        checks++; if (bus.memReq !== 1'b0 || bus.flush !== 1'b0) begin errors++; $display("FAIL reset_outs: memReq=%b flush=%b want 0 0", bus.memReq, bus.flush); end
        checks++; if (bus.decReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.decReady); end
    endtask

    task automatic test_raw_hazard();
        do_reset();
        set_op(2, 2, 3, 1, 1'b1);                        // ADD X1,X2,X3
        #1;
        checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL raw_add_issue: got %b want 1", bus.issue); end
        tick();
        checks++; if (bus.inflightCount !== 3'd1) begin errors++; $display("FAIL raw_add_count: got %0d want 1", bus.inflightCount); end
        set_op(2, 1, 5, 4, 1'b1);                        // SUB X4,X1,X5
        #1;
        checks++; if (bus.decReady !== 1'b0) begin errors++; $display("FAIL raw_sub_blocked: got %b want 0", bus.decReady); end
        tick();
        checks++; if (bus.stallCount !== 16'd1) begin errors++; $display("FAIL raw_stall: got %0d want 1", bus.stallCount); end
        bus.wbValid = 1'b1; bus.wbRegister = 5'd1;
        #1;
        checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL raw_bypass_issue: got %b want 1", bus.issue); end
        tick();
        checks++; if (bus.inflightCount !== 3'd1) begin errors++; $display("FAIL raw_after_wb: got %0d want 1", bus.inflightCount); end
        idle_inputs(); bus.wbValid = 1'b1; bus.wbRegister = 5'd4;
        tick();
        bus.wbRegister = 5'd31;                          // XZR writeback is ignored
        tick();
        checks++; if (bus.inflightCount !== 3'd0) begin errors++; $display("FAIL raw_drain: got %0d want 0", bus.inflightCount); end
    endtask

    task automatic test_load();
        int hi;
        hi = 0;
        do_reset();
        set_op(0, 2, 0, 6, 1'b1);                        // LDUR X6,[X2]
        #1;
        checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL ld_issue: got %b want 1", bus.issue); end
        tick();
        set_op(2, 3, 4, 8, 1'b1);
        for (int k = 0; k < 4; k++) begin
            bus.memAck = (k == 3);
            #1;
            checks++; if (bus.decReady !== 1'b0) begin errors++; $display("FAIL ld_mem_ready c%0d: got %b want 0", k, bus.decReady); end
            if (bus.memReq === 1'b1) hi++;
            tick();
        end
        bus.memAck = 1'b0;
        #1;
        checks++; if (bus.memReq !== 1'b0) begin errors++; $display("FAIL ld_memreq_clear: got %b want 0", bus.memReq); end
        checks++; if (hi != 4) begin errors++; $display("FAIL ld_memreq_len: got %0d want 4", hi); end
        checks++; if (bus.stallCount !== 16'd4) begin errors++; $display("FAIL ld_stall: got %0d want 4", bus.stallCount); end
        checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL ld_next_issue: got %b want 1", bus.issue); end
        tick();
        idle_inputs();
        bus.memAck = 1'b1;                               // stray ack outside MEM
        tick();
        checks++; if (bus.memReq !== 1'b0) begin errors++; $display("FAIL ld_stray_ack: got %b want 0", bus.memReq); end
    endtask

    task automatic test_branch();
        do_reset();
        set_op(1, 0, 3, 0, 1'b0);                        // CBZ X3
        #1;
        checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL cb_issue: got %b want 1", bus.issue); end
        tick();
        bus.decValid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (bus.flush !== 1'b0 || bus.decReady !== 1'b0) begin errors++; $display("FAIL cb_wait c%0d: flush=%b ready=%b want 0 0", k, bus.flush, bus.decReady); end
            tick();
        end
        bus.branchResolved = 1'b1; bus.branchTaken = 1'b1;
        tick();
        bus.branchResolved = 1'b0; bus.branchTaken = 1'b0;
        #1;
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL cb_taken_flush: got %b want 1", bus.flush); end
        checks++; if (bus.decReady !== 1'b1) begin errors++; $display("FAIL cb_run_during_flush: got %b want 1", bus.decReady); end
        tick();
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL cb_flush_pulse: got %b want 0", bus.flush); end
        set_op(1, 0, 3, 0, 1'b0);
        tick();
        bus.decValid = 1'b0; bus.branchResolved = 1'b1; bus.branchTaken = 1'b0;
        tick();
        bus.branchResolved = 1'b0;
        #1;
        checks++; if (bus.flush !== 1'b0 || bus.decReady !== 1'b1) begin errors++; $display("FAIL cb_not_taken: flush=%b ready=%b want 0 1", bus.flush, bus.decReady); end
        set_op(5, 0, 0, 0, 1'b0);                        // B
        tick();
        bus.decValid = 1'b0;
        #1;
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL b_flush: got %b want 1", bus.flush); end
        tick();
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL b_flush_pulse: got %b want 0", bus.flush); end
    endtask

    task automatic test_inflight();
        do_reset();
        for (int k = 0; k < 4; k++) begin set_op(4, 20, 0, 10 + k, 1'b1); tick(); end
        checks++; if (bus.inflightCount !== 3'd4) begin errors++; $display("FAIL inf_full: got %0d want 4", bus.inflightCount); end
        set_op(2, 20, 21, 14, 1'b1);
        #1;
        checks++; if (bus.decReady !== 1'b0) begin errors++; $display("FAIL inf_fifth: got %b want 0", bus.decReady); end
        set_op(2, 20, 21, 31, 1'b1);
        #1;
        checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL inf_xzr: got %b want 1", bus.issue); end
        tick();
        set_op(7, 20, 21, 0, 1'b0);
        #1;
        checks++; if (bus.decReady !== 1'b0) begin errors++; $display("FAIL illegal_op: got %b want 0", bus.decReady); end
        set_op(2, 20, 21, 14, 1'b1); bus.wbValid = 1'b1; bus.wbRegister = 5'd13;
        #1;
        checks++; if (bus.decReady !== 1'b0) begin errors++; $display("FAIL inf_full_with_wb: got %b want 0", bus.decReady); end
        tick();
        set_op(2, 20, 21, 10, 1'b1); bus.wbValid = 1'b1; bus.wbRegister = 5'd10;
        #1;
        checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL inf_setclr_issue: got %b want 1", bus.issue); end
        tick();
        checks++; if (bus.inflightCount !== 3'd3) begin errors++; $display("FAIL inf_setclr_count: got %0d want 3", bus.inflightCount); end
        bus.wbValid = 1'b0; set_op(4, 10, 0, 0, 1'b0);
        #1;
        checks++; if (bus.decReady !== 1'b0) begin errors++; $display("FAIL inf_set_wins: got %b want 0", bus.decReady); end
        idle_inputs();
    endtask

    task automatic test_random();
        int r[4];
        for (int n = 0; n < 400; n++) begin
            for (int j = 0; j < 4; j++) begin r[j] = $urandom_range(0, 8); if (r[j] == 8) r[j] = 31; end
            set_op($urandom_range(0, 7), r[0], r[1], r[2], $urandom_range(0, 1));
            bus.decValid = ($urandom_range(0, 3) != 0);
            if (bus.regWriteFlag && r[2] != 31 && m_pend[r[2]]) bus.regWriteFlag = 1'b0;
            bus.wbValid = ($urandom_range(0, 2) == 0); bus.wbRegister = 5'(r[3]);
            bus.memAck = ($urandom_range(0, 2) == 0);
            bus.branchResolved = ($urandom_range(0, 2) == 0); bus.branchTaken = $urandom_range(0, 1);
            #1;
            checks++; if (bus.decReady !== m_ready() || bus.issue !== (bus.decValid && m_ready())) begin
                errors++; $display("FAIL rnd_ready n%0d: ready=%b issue=%b want %b %b", n, bus.decReady, bus.issue, m_ready(), bus.decValid && m_ready()); end
            tick();
            checks++; if (bus.memReq !== m_memreq || bus.flush !== m_flush || bus.inflightCount !== 3'(m_cnt) || bus.stallCount !== 16'(m_stall)) begin
                errors++; $display("FAIL rnd_state n%0d: memReq=%b flush=%b cnt=%0d stall=%0d want %b %b %0d %0d",
                                   n, bus.memReq, bus.flush, bus.inflightCount, bus.stallCount, m_memreq, m_flush, m_cnt, m_stall); end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_op(0, 2, 0, 7, 1'b1);
        tick();
        bus.decValid = 1'b0;
        #1;
        checks++; if (bus.memReq !== 1'b1) begin errors++; $display("FAIL mid_memreq_up: got %b want 1", bus.memReq); end
        #2;
        resetN = 1'b0;
        #1;
        checks++; if (bus.memReq !== 1'b0 || bus.inflightCount !== 3'd0) begin errors++; $display("FAIL mid_async: memReq=%b cnt=%0d want 0 0", bus.memReq, bus.inflightCount); end
        model_reset();
        @(negedge clock);
        resetN = 1'b1;
        bus.memAck = 1'b1;
        set_op(2, 7, 7, 0, 1'b0);                        // reads X7, which the aborted load wrote
        #1;
        checks++; if (bus.decReady !== 1'b1) begin errors++; $display("FAIL mid_run_clear: got %b want 1", bus.decReady); end
        tick();
        checks++; if (bus.memReq !== 1'b0 || bus.flush !== 1'b0) begin errors++; $display("FAIL mid_late_ack: memReq=%b flush=%b want 0 0", bus.memReq, bus.flush); end
        idle_inputs();
    endtask

    task automatic test_stall_saturate();
        do_reset();
        set_op(7, 0, 0, 0, 1'b0);
        repeat (70000) tick();
        checks++; if (bus.stallCount !== 16'hFFFF || m_stall != 65535) begin errors++; $display("FAIL stall_sat: got %0h want ffff", bus.stallCount); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_raw_hazard();
        test_load();
        test_branch();
        test_inflight();
        test_random();
        test_reset_mid();
        test_stall_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
